enemy_spawner: RTL and testbench

- Game-side controller that drives the spawn interface of a pool of NUM_SLOTS enemy slots and consumes each slot's alive/killed/collision status.
- Issues paced, pseudo-random spawn requests (angle, kind) to free slots.
- Scores kills by enemy kind, deducts lives on collisions and raises difficulty (level, spawn rate).
- Sits between the top-level game FSM/HUD and the enemy instances.

---
 rtl/enemy_spawner.sv | 198 +++++++++++++++++++
 tb/tb_enemy_spawner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_spawner.sv
// Enemy spawn controller. It paces pseudo-random spawns into free slots and turns
// per-slot kill and collision edges into score, lives and difficulty.
module enemy_spawner #(
    parameter int unsigned NUM_SLOTS       = 8,
    parameter int unsigned SPAWN_PERIOD    = 50000000,
    parameter int unsigned PERIOD_STEP     = 5000000,
    parameter int unsigned MIN_PERIOD      = 12500000,
    parameter int unsigned KILLS_PER_LEVEL = 8,
    parameter int unsigned START_LIVES     = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_SLOTS-1:0] slot_alive,
    input  logic [NUM_SLOTS-1:0] slot_killed,
    input  logic [NUM_SLOTS-1:0] slot_collision,
    output logic [NUM_SLOTS-1:0] spawn,
    output logic [3:0]           new_angle,
    output logic [1:0]           new_kind,
    output logic [15:0]          score,
    output logic [2:0]           lives,
    output logic [3:0]           level,
    output logic                 running,
    output logic                 game_over
);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t               state_reg, state_next;
    logic [15:0]          lfsr_reg, lfsr_next;
    logic [31:0]          period_reg, active_period_reg, timer_reg;
    logic [15:0]          kill_cnt_reg, score_reg;
    logic [2:0]           lives_reg;
    logic [3:0]           level_reg, angle_reg;
    logic [1:0]           kind_reg;
    logic [NUM_SLOTS-1:0] spawn_reg;
    logic [NUM_SLOTS-1:0] coll_prev_reg, kill_prev_reg, coll_evt_reg, kill_evt_reg;

    logic                 in_run, enter_run, pending, spawn_fire, free_found, level_up;
    logic [NUM_SLOTS-1:0] free_onehot, scored;
    logic [2:0]           slot_points [NUM_SLOTS];
    logic [6:0]           score_delta;
    logic [4:0]           kill_count, coll_count;
    logic [16:0]          score_sum;
    logic [15:0]          score_upd, kill_sum;
    logic [2:0]           lives_upd;
    logic [3:0]           angle_pick;
    logic [1:0]           kind_pick;

    assign in_run     = (state_reg == RUN);
    // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    assign lfsr_next  = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign angle_pick = (lfsr_reg[3:0] == angle_reg) ? lfsr_reg[3:0] + 4'd1 : lfsr_reg[3:0];
    assign kind_pick  = (lfsr_reg[5:4] == 2'd3) ? 2'd0 : lfsr_reg[5:4];
    assign pending    = (timer_reg == active_period_reg - 32'd1);
    assign spawn_fire = in_run && (state_next == RUN) && pending && free_found;

    always_comb begin
        free_found  = 1'b0;
        free_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!free_found && !slot_alive[i]) begin
                free_found     = 1'b1;
                free_onehot[i] = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic [1:0] slot_kind_reg;
            logic       collided_reg;
            logic       coll_kill;

            // a kill on a slot that collided (earlier or in the same cycle) earns nothing
            assign coll_kill        = collided_reg | coll_evt_reg[gi];
            assign scored[gi]       = in_run & kill_evt_reg[gi] & ~coll_kill;
            assign slot_points[gi]  = !scored[gi]               ? 3'd0 :
                                      (slot_kind_reg == 2'd2)   ? 3'd4 :
                                      (slot_kind_reg == 2'd1)   ? 3'd2 : 3'd1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_kind_reg <= 2'd0;
                    collided_reg  <= 1'b0;
                end else if (spawn_fire && free_onehot[gi]) begin
                    slot_kind_reg <= kind_pick;
                    collided_reg  <= 1'b0;
                end else if (in_run && kill_evt_reg[gi]) begin
                    collided_reg  <= 1'b0;
                end else if (in_run && coll_evt_reg[gi]) begin
                    collided_reg  <= 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        score_delta = '0;
        kill_count  = '0;
        coll_count  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            score_delta = score_delta + 7'(slot_points[i]);
            kill_count  = kill_count + 5'(scored[i]);
            coll_count  = coll_count + 5'(coll_evt_reg[i]);
        end
        score_sum = {1'b0, score_reg} + 17'(score_delta);
        score_upd = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        lives_upd = (5'(lives_reg) > coll_count) ? lives_reg - 3'(coll_count) : 3'd0;
        kill_sum  = kill_cnt_reg + 16'(kill_count);
        level_up  = (kill_sum >= 16'(KILLS_PER_LEVEL));
    end

    always_comb begin
        state_next = state_reg;
        enter_run  = 1'b0;
        case (state_reg)
            IDLE, OVER: begin
                if (start) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN:     if (lives_upd == 3'd0) state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            lfsr_reg          <= LFSR_SEED;
            period_reg        <= SPAWN_PERIOD;
            active_period_reg <= SPAWN_PERIOD;
            timer_reg         <= '0;
            kill_cnt_reg      <= '0;
            score_reg         <= '0;
            lives_reg         <= 3'(START_LIVES);
            level_reg         <= '0;
            angle_reg         <= '0;
            kind_reg          <= '0;
            spawn_reg         <= '0;
            coll_prev_reg     <= '0;
            kill_prev_reg     <= '0;
            coll_evt_reg      <= '0;
            kill_evt_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            lfsr_reg      <= lfsr_next;
            coll_prev_reg <= slot_collision;
            kill_prev_reg <= slot_killed;
            coll_evt_reg  <= slot_collision & ~coll_prev_reg;
            kill_evt_reg  <= slot_killed & ~kill_prev_reg & slot_alive;
            spawn_reg     <= spawn_fire ? free_onehot : '0;
            if (spawn_fire) begin
                angle_reg <= angle_pick;
                kind_reg  <= kind_pick;
            end
            if (enter_run) begin
                score_reg         <= '0;
                lives_reg         <= 3'(START_LIVES);
                level_reg         <= '0;
                period_reg        <= SPAWN_PERIOD;
                active_period_reg <= SPAWN_PERIOD;
                timer_reg         <= '0;
                kill_cnt_reg      <= '0;
            end else if (in_run) begin
                score_reg <= score_upd;
                lives_reg <= lives_upd;
                if (level_up) begin
                    kill_cnt_reg <= kill_sum - 16'(KILLS_PER_LEVEL);
                    if (level_reg != 4'd15) level_reg <= level_reg + 4'd1;
                    period_reg <= (period_reg > MIN_PERIOD + PERIOD_STEP) ?
                                  period_reg - PERIOD_STEP : MIN_PERIOD;
                end else begin
                    kill_cnt_reg <= kill_sum;
                end
                // a new period is only picked up when the timer restarts
                if (spawn_fire) begin
                    timer_reg         <= '0;
                    active_period_reg <= period_reg;
                end else if (!pending) begin
                    timer_reg <= timer_reg + 32'd1;
                end
            end
        end
    end

    assign spawn     = spawn_reg;
    assign new_angle = angle_reg;
    assign new_kind  = kind_reg;
    assign score     = score_reg;
    assign lives     = lives_reg;
    assign level     = level_reg;
    assign running   = (state_reg == RUN);
    assign game_over = (state_reg == OVER);
endmodule

// File: tb/tb_enemy_spawner.sv
// Directed game scenario with randomized kill choice, checked against a
// transaction-level model of score, lives, level, period and spawn contents.
module tb_enemy_spawner;
    localparam int NS   = 8;
    localparam int SP   = 16;
    localparam int STEP = 6;
    localparam int MINP = 4;
    localparam int KPL  = 2;
    localparam int SL   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NS-1:0] slot_alive = '0;
    logic [NS-1:0] slot_killed = '0;
    logic [NS-1:0] slot_collision = '0;
    logic [NS-1:0] spawn;
    logic [3:0]    new_angle;
    logic [1:0]    new_kind;
    logic [15:0]   score;
    logic [2:0]    lives;
    logic [3:0]    level;
    logic          running;
    logic          game_over;

    enemy_spawner #(
        .NUM_SLOTS(NS), .SPAWN_PERIOD(SP), .PERIOD_STEP(STEP), .MIN_PERIOD(MINP),
        .KILLS_PER_LEVEL(KPL), .START_LIVES(SL), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .slot_alive(slot_alive),
        .slot_killed(slot_killed), .slot_collision(slot_collision), .spawn(spawn),
        .new_angle(new_angle), .new_kind(new_kind), .score(score), .lives(lives),
        .level(level), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nspawn = 0;

    // reference model state
    logic [15:0] m_lfsr;
    logic [3:0]  m_prev_angle;
    logic [1:0]  m_kind [NS];
    bit          m_coll [NS];
    bit          m_run;
    int          m_score, m_lives, m_level, m_kcnt, m_period;
    logic [3:0]  rec_angle [2];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) begin
            r[16-1] = ~r[16-1];
            r[14-1] = ~r[14-1];
            r[13-1] = ~r[13-1];
            r[11-1] = ~r[11-1];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_angle = 4'd0;
        for (int i = 0; i < NS; i++) begin
            m_kind[i] = 2'd0;
            m_coll[i] = 1'b0;
        end
        m_run = 1'b0; m_score = 0; m_lives = SL; m_level = 0; m_kcnt = 0; m_period = SP;
    endtask

    // one clock; validates any spawn pulse against the model and marks the slot alive
    task automatic tick();
        logic [15:0] lf;
        logic [NS-1:0] alive_e, exp_oh;
        logic rst_e;
        logic [3:0] ea;
        logic [1:0] ek;
        int s;
        lf = m_lfsr; alive_e = slot_alive; rst_e = rst;
        @(posedge clk);
        m_lfsr = rst_e ? SEED : lfsr_step(m_lfsr);
        #1;
        if (!rst_e && spawn !== '0) begin
            s = -1;
            exp_oh = '0;
            for (int i = NS - 1; i >= 0; i--) if (!alive_e[i]) s = i;
            if (s >= 0) exp_oh[s] = 1'b1;
            chk("spawn_slot", {23'd0, !m_run, spawn}, {24'd0, exp_oh});
            ea = lf[3:0];
            if (ea == m_prev_angle) ea = ea + 4'd1;
            ek = (lf[5:4] == 2'd3) ? 2'd0 : lf[5:4];
            chk("spawn_angle", 32'(new_angle), 32'(ea));
            chk("spawn_kind", 32'(new_kind), 32'(ek));
            m_prev_angle = ea;
            if (s >= 0) begin
                m_kind[s] = ek;
                m_coll[s] = 1'b0;
                slot_alive[s] = 1'b1;
            end
            nspawn++;
        end
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_run = 1'b1; m_score = 0; m_lives = SL; m_level = 0; m_kcnt = 0; m_period = SP;
    endtask

    task automatic do_kill(input int s);
        logic a;
        int p;
        a = slot_alive[s];
        slot_killed[s] = 1'b1;
        tick();
        slot_killed[s] = 1'b0;
        slot_alive[s] = 1'b0;
        if (m_run && a) begin
            if (m_coll[s]) begin
                m_coll[s] = 1'b0;
            end else begin
                p = (m_kind[s] == 2'd2) ? 4 : (m_kind[s] == 2'd1) ? 2 : 1;
                m_score = (m_score + p > 65535) ? 65535 : m_score + p;
                m_kcnt++;
                if (m_kcnt >= KPL) begin
                    m_kcnt -= KPL;
                    if (m_level < 15) m_level++;
                    m_period = (m_period - STEP > MINP) ? m_period - STEP : MINP;
                end
            end
        end
    endtask

    task automatic collide(input logic [NS-1:0] mask, input int hold);
        int c;
        slot_collision = mask;
        repeat (hold) tick();
        slot_collision = '0;
        if (m_run) begin
            c = $countones(mask);
            m_lives = (m_lives > c) ? m_lives - c : 0;
            for (int i = 0; i < NS; i++) if (mask[i]) m_coll[i] = 1'b1;
            if (m_lives == 0) m_run = 1'b0;
        end
    endtask

    task automatic wait_spawn(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (spawn === '0 && n < 60);
    endtask

    task automatic measure_period(input string tag);
        int n;
        slot_alive = '0;
        n = 0;
        while (spawn === '0 && n < 60) begin
            tick();
            n++;
        end
        for (int k = 0; k < 2; k++) wait_spawn(n);
        chk(tag, n, m_period);
    endtask

    task automatic intro(input int pass);
        int n;
        slot_alive = '0; slot_killed = '0; slot_collision = '0; start = 1'b0;
        rst = 1'b1;
        tick();
        model_reset();
        chk("rst_spawn", 32'(spawn), 0);
        chk("rst_angle", 32'(new_angle), 0);
        chk("rst_kind", 32'(new_kind), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), SL);
        chk("rst_level", 32'(level), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_game_over", 32'(game_over), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        start_game();
        chk("start_running", 32'(running), 1);
        wait_spawn(n);
        chk("first_spawn_delay", n, SP);
        chk("first_spawn_slot", 32'(spawn), 32'h01);
        if (pass == 0) rec_angle[0] = m_prev_angle;
        else chk("replay_angle0", 32'(new_angle), 32'(rec_angle[0]));
        tick();
        chk("spawn_width", 32'(spawn), 0);
        wait_spawn(n);
        chk("second_spawn_delay", n + 1, SP);
        chk("second_spawn_slot", 32'(spawn), 32'h02);
        if (pass == 0) rec_angle[1] = m_prev_angle;
        else chk("replay_angle1", 32'(new_angle), 32'(rec_angle[1]));
    endtask

    initial begin
        int n, base, guard, s;
        int cand[$];

        intro(0);

        // every slot busy: the timer expires but nothing may be issued
        slot_alive = '1;
        base = nspawn;
        repeat (36) tick();
        chk("blocked_no_spawn", nspawn - base, 0);
        slot_alive[5] = 1'b0;
        n = 0;
        while (spawn === '0 && n < 5) begin
            tick();
            n++;
        end
        chk("release_latency_ok", (n >= 1 && n <= 2), 1);
        chk("release_slot", 32'(spawn), 32'h20);
        slot_alive[6] = 1'b0;
        wait_spawn(n);
        chk("restart_delay", n, SP);
        chk("restart_slot", 32'(spawn), 32'h40);

        do_kill(5);
        settle();
        chk("kill_score", 32'(score), m_score);
        slot_alive[7] = 1'b0;
        do_kill(7);
        settle();
        chk("dead_kill_score", 32'(score), m_score);

        slot_alive[3] = 1'b1;
        collide(8'h08, 2);
        do_kill(3);
        settle();
        chk("coll_kill_lives", 32'(lives), m_lives);
        chk("coll_kill_score", 32'(score), m_score);

        for (int target = 1; target <= 3; target += 2) begin
            guard = 0;
            while (m_level < target && guard < 300) begin
                cand.delete();
                for (int i = 0; i < NS; i++) if (slot_alive[i]) cand.push_back(i);
                if (cand.size() == 0) begin
                    tick();
                end else begin
                    s = cand[$urandom_range(0, cand.size() - 1)];
                    do_kill(s);
                    settle();
                    chk("level_score", 32'(score), m_score);
                    repeat ($urandom_range(0, 3)) tick();
                end
                guard++;
            end
            settle();
            chk("level_value", 32'(level), m_level);
            chk("level_lives", 32'(lives), m_lives);
            measure_period("spawn_period");
        end

        collide(8'h07, 1);
        settle();
        chk("over_lives", 32'(lives), 0);
        chk("over_flag", 32'(game_over), 1);
        chk("over_running", 32'(running), 0);
        chk("over_level_hold", 32'(level), m_level);
        chk("over_score_hold", 32'(score), m_score);
        slot_alive = '0;
        base = nspawn;
        repeat (40) tick();
        chk("over_no_spawn", nspawn - base, 0);

        start_game();
        chk("restart_score", 32'(score), 0);
        chk("restart_lives", 32'(lives), SL);
        slot_alive = '1;
        repeat (20) tick();
        intro(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
